xcr_pae32_refill: RTL and testbench
===================================

# xcr_pae32_refill

Hardware refill sequencer for the PAE32 MMU control registers. On an instruction- or data-side tag miss, it fetches a 16-bit page-table entry from memory through a byte-wide read port. It then programs the MMU through the XCR bus: the PA high bytes first, then the VA tag. It serialises instruction and data misses, arbitrates for the XCR bus against the CPU, and signals completion or page fault back to the requester.

## Interface
- No parameters; widths are fixed by the PAE32 register map.
- clk  in  1  system clock
- rst  in  1  one clock; reset is synchronous and active-high
- mmu_enable  in  1  from MMU control; walks start only when 1
- supervisor_mode  in  1  from MMU control; walks start only when 0
- pt_base  in  16  page-table base, PA[31:16]
- imiss_req  in  1  level; instruction VA tag miss pending
- imiss_vpn  in  8  instruction VA[23:16]
- dmiss_req  in  1  level; data VA tag miss pending
- dmiss_vpn  in  8  data VA[23:16]
- iack / dack  out  1  one-cycle pulse; refill of that side complete
- ifault / dfault  out  1  one-cycle pulse; invalid PTE, nothing written
- mem_req  out  1  read request; held until accepted
- mem_adr  out  32  byte address
- mem_rdy  in  1  read accepted, data valid this cycle
- mem_rdata  in  8  read data
- xcr_busy  in  1  CPU owns the XCR bus this cycle
- xcr_cs, xcr_we  out  1  XCR write strobe, both asserted together
- xcr_adr  out  3  XCR register index
- xcr_wdat  out  8  XCR write data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD_HI, RD_LO, WR_PAH, WR_PAL, WR_TAG, DONE, FAULT.
- Start condition (IDLE): mmu_enable & !supervisor_mode & (dmiss_req | imiss_req).
  - If the start condition is false, the block stays in IDLE and requests remain pending.
- Priority: data side wins over instruction side.
  - On start, latch side (1 = data) and vpn; go to RD_HI.
- Entry address: {pt_base, 6'b0, side, vpn, bsel}, with bsel=0 for PA[31:24] and bsel=1 for PA[23:16].
- RD_HI: mem_req=1, bsel=0; when mem_rdy, latch pa_hi and go to RD_LO.
- RD_LO: mem_req=1, bsel=1; when mem_rdy, latch pa_lo.
  - Go to FAULT if {pa_hi, mem_rdata} == 16'hFFFF, else go to WR_PAH.
- WR_PAH, WR_PAL, WR_TAG: drive one XCR write each; advance only in a cycle with xcr_busy=0.
  - Instruction side: adr 3 = pa_hi, adr 4 = pa_lo, adr 2 = vpn.
  - Data side: adr 6 = pa_hi, adr 7 = pa_lo, adr 5 = vpn.
  - The tag is always written last, so the new tag never matches before its PA is complete.
- DONE: pulse iack or dack per the latched side; return to IDLE.
- FAULT: pulse ifault or dfault; no XCR write occurs; return to IDLE.
- Requester deasserting its request mid-walk: the walk completes and ack/fault is still pulsed.
- Requester holding its request after ack: treated as a new miss on the next IDLE cycle. The requester must drop it within the ack cycle.
- mmu_enable or supervisor_mode changing mid-walk does not abort the walk.
- rst has priority over all state transitions.
  - Reset mid-walk returns to IDLE and leaves no partial tag write.
  - Any PA bytes already written remain; MMU control is itself reset to disabled.

## Timing
- Reset values: all outputs 0; state IDLE; internal latches 0.
- mem_req, mem_adr and the xcr_* outputs are registered-state decodes, stable for the whole state.
- xcr_cs/xcr_we are asserted only in WR_* states with xcr_busy=0; xcr_adr and xcr_wdat are 0 otherwise.
- Minimum latency, with mem_rdy=1 and xcr_busy=0 throughout:
  - request sampled in IDLE at cycle 0;
  - reads at cycles 1–2;
  - XCR writes at cycles 3–5;
  - ack at cycle 6.
- Fault path: fault pulse at cycle 3.
- Each mem_rdy=0 cycle or xcr_busy=1 cycle adds exactly one cycle.
- Back-to-back: when both sides miss, the data side acks at cycle 6, IDLE occupies cycle 7, and the instruction walk reads from cycle 8.

## Structure
- Shared package: state enum; XCR index constants (IPTE=2, IPAE0=3, IPAE1=4, DPTE=5, DPAE0=6, DPAE1=7); PTE_INVALID=16'hFFFF.
- Single FSM module with no sub-module.

## Test plan
- Data refill: pt_base=16'h0012, dmiss_vpn=8'h34, memory at 0x0012_0268 = 8'hAB and 0x0012_0269 = 8'hCD.
  - Expect writes adr6=AB, adr7=CD, adr5=34, in that order; dack at cycle 6.
- Simultaneous imiss_vpn=8'h01 and dmiss_vpn=8'h02 → data walk completes first; instruction walk reads 0x....0002 and 0x....0003, then writes adr 3, 4, 2.
- PTE bytes FF, FF → dfault pulse at cycle 3; no xcr_cs asserted.
- xcr_busy high for 4 cycles in WR_PAL and mem_rdy delayed 2 cycles in RD_HI → ack at cycle 12; write order unchanged.
- mmu_enable=0 with imiss_req held → block stays in IDLE and mem_req stays 0.
  - Set mmu_enable=1 → walk starts the next cycle.
- rst asserted during WR_PAL → next cycle IDLE, all outputs 0, no tag write ever occurs.

Source files
------------

// File: rtl/xcr_pae32_refill_pkg.sv
// xcr_pae32_refill_pkg
// Shared types and constants for the PAE32 MMU refill sequencer:
//   state_t      - refill FSM state encoding
//   XCR_*        - XCR register indices of the PAE32 register map
//   PTE_INVALID  - page-table entry value that marks an unmapped page
//   xcr_idx()    - register index for a given side and write step
package xcr_pae32_refill_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_HI  = 3'd1,
    S_RD_LO  = 3'd2,
    S_WR_PAH = 3'd3,
    S_WR_PAL = 3'd4,
    S_WR_TAG = 3'd5,
    S_DONE   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0]  XCR_IPTE    = 3'd2;
  localparam logic [2:0]  XCR_IPAE0   = 3'd3;
  localparam logic [2:0]  XCR_IPAE1   = 3'd4;
  localparam logic [2:0]  XCR_DPTE    = 3'd5;
  localparam logic [2:0]  XCR_DPAE0   = 3'd6;
  localparam logic [2:0]  XCR_DPAE1   = 3'd7;
  localparam logic [15:0] PTE_INVALID = 16'hFFFF;

  // step: 0 = PA high byte, 1 = PA low byte, 2 = VA tag
  function automatic logic [2:0] xcr_idx(input logic side, input logic [1:0] step);
    logic [2:0] idx;
    idx = 3'd0;
    case (step)
      2'd0:    idx = side ? XCR_DPAE0 : XCR_IPAE0;
      2'd1:    idx = side ? XCR_DPAE1 : XCR_IPAE1;
      default: idx = side ? XCR_DPTE  : XCR_IPTE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/xcr_pae32_refill.sv
// xcr_pae32_refill
// Hardware page-table walker for PAE32 MMU tag misses. Fetches a 16-bit PTE
// over a byte-wide read port, then programs PA high, PA low and finally the
// VA tag through the XCR bus. Data-side misses take priority.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mmu_enable, supervisor_mode walk start qualifiers
//   pt_base[15:0]               page-table base, PA[31:16]
//   imiss_req/imiss_vpn[7:0]    instruction-side miss request and VA[23:16]
//   dmiss_req/dmiss_vpn[7:0]    data-side miss request and VA[23:16]
//   iack/dack, ifault/dfault    one-cycle completion / page-fault pulses
//   mem_req/mem_adr[31:0]       PTE byte read request and address
//   mem_rdy/mem_rdata[7:0]      read accept and data
//   xcr_busy                    CPU owns the XCR bus this cycle
//   xcr_cs/xcr_we/xcr_adr/xcr_wdat  XCR write port
//   busy                        walker not idle
module xcr_pae32_refill
  import xcr_pae32_refill_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mmu_enable,
  input  logic        supervisor_mode,
  input  logic [15:0] pt_base,
  input  logic        imiss_req,
  input  logic [7:0]  imiss_vpn,
  input  logic        dmiss_req,
  input  logic [7:0]  dmiss_vpn,
  output logic        iack,
  output logic        dack,
  output logic        ifault,
  output logic        dfault,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata,
  input  logic        xcr_busy,
  output logic        xcr_cs,
  output logic        xcr_we,
  output logic [2:0]  xcr_adr,
  output logic [7:0]  xcr_wdat,
  output logic        busy
);

  state_t     state, state_nx;
  logic       side_q;            // 1 = data side
  logic [7:0] vpn_q;
  logic [7:0] pa_hi_q;
  logic [7:0] pa_lo_q;
  logic       start;

  assign start = mmu_enable & ~supervisor_mode & (dmiss_req | imiss_req);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      side_q  <= 1'b0;
      vpn_q   <= 8'h00;
      pa_hi_q <= 8'h00;
      pa_lo_q <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        side_q <= dmiss_req;
        vpn_q  <= dmiss_req ? dmiss_vpn : imiss_vpn;
      end
      if (state == S_RD_HI && mem_rdy) pa_hi_q <= mem_rdata;
      if (state == S_RD_LO && mem_rdy) pa_lo_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_adr  = 32'h0;
    xcr_cs   = 1'b0;
    xcr_we   = 1'b0;
    xcr_adr  = 3'd0;
    xcr_wdat = 8'h00;
    iack     = 1'b0;
    dack     = 1'b0;
    ifault   = 1'b0;
    dfault   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RD_HI;
      end
      S_RD_HI: begin
        mem_req = 1'b1;
        mem_adr = {pt_base, 6'b0, side_q, vpn_q, 1'b0};
        if (mem_rdy) state_nx = S_RD_LO;
      end
      S_RD_LO: begin
        mem_req = 1'b1;
        mem_adr = {pt_base, 6'b0, side_q, vpn_q, 1'b1};
        // Fault check uses the live low byte so no extra cycle is spent.
        if (mem_rdy) state_nx = ({pa_hi_q, mem_rdata} == PTE_INVALID) ? S_FAULT : S_WR_PAH;
      end
      S_WR_PAH: begin
        xcr_adr  = xcr_idx(side_q, 2'd0);
        xcr_wdat = pa_hi_q;
        xcr_cs   = ~xcr_busy;
        xcr_we   = ~xcr_busy;
        if (!xcr_busy) state_nx = S_WR_PAL;
      end
      S_WR_PAL: begin
        xcr_adr  = xcr_idx(side_q, 2'd1);
        xcr_wdat = pa_lo_q;
        xcr_cs   = ~xcr_busy;
        xcr_we   = ~xcr_busy;
        if (!xcr_busy) state_nx = S_WR_TAG;
      end
      // Tag goes last so a lookup can never hit a half-written PA.
      S_WR_TAG: begin
        xcr_adr  = xcr_idx(side_q, 2'd2);
        xcr_wdat = vpn_q;
        xcr_cs   = ~xcr_busy;
        xcr_we   = ~xcr_busy;
        if (!xcr_busy) state_nx = S_DONE;
      end
      S_DONE: begin
        iack     = ~side_q;
        dack     = side_q;
        state_nx = S_IDLE;
      end
      S_FAULT: begin
        ifault   = ~side_q;
        dfault   = side_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xcr_pae32_refill.sv
module tb_xcr_pae32_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmu_enable = 1'b0;
  logic        supervisor_mode = 1'b0;
  logic [15:0] pt_base = 16'h0;
  logic        imiss_req = 1'b0;
  logic [7:0]  imiss_vpn = 8'h0;
  logic        dmiss_req = 1'b0;
  logic [7:0]  dmiss_vpn = 8'h0;
  logic        iack, dack, ifault, dfault;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_rdy = 1'b1;
  logic [7:0]  mem_rdata = 8'h0;
  logic        xcr_busy = 1'b0;
  logic        xcr_cs, xcr_we;
  logic [2:0]  xcr_adr;
  logic [7:0]  xcr_wdat;
  logic        busy;

  xcr_pae32_refill dut (
    .clk(clk), .rst(rst), .mmu_enable(mmu_enable), .supervisor_mode(supervisor_mode),
    .pt_base(pt_base), .imiss_req(imiss_req), .imiss_vpn(imiss_vpn),
    .dmiss_req(dmiss_req), .dmiss_vpn(dmiss_vpn), .iack(iack), .dack(dack),
    .ifault(ifault), .dfault(dfault), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .xcr_busy(xcr_busy), .xcr_cs(xcr_cs),
    .xcr_we(xcr_we), .xcr_adr(xcr_adr), .xcr_wdat(xcr_wdat), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int         cyc;
  int         wr_n, we_bad;
  logic [2:0] wr_adr [16];
  logic [7:0] wr_dat [16];
  int         wr_cyc [16];
  int         dack_cyc, iack_cyc, dfault_cyc, ifault_cyc;
  int         dack_n, iack_n, dfault_n, ifault_n;
  logic [31:0] adr_log [64];
  logic        req_log [64];
  logic        busy_log [64];
  int          rdy_lo_a, rdy_lo_b, busy_a, busy_b;

  function automatic logic [7:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0012_0268: return 8'hAB;
      32'h0012_0269: return 8'hCD;
      32'h0040_02EE: return 8'hFF;
      32'h0040_02EF: return 8'hFF;
      default:       return a[7:0] + 8'h10;
    endcase
  endfunction

  task automatic clear_log;
    cyc = 0; wr_n = 0; we_bad = 0;
    dack_cyc = -1; iack_cyc = -1; dfault_cyc = -1; ifault_cyc = -1;
    dack_n = 0; iack_n = 0; dfault_n = 0; ifault_n = 0;
    rdy_lo_a = -1; rdy_lo_b = -1; busy_a = -1; busy_b = -1;
    for (int i = 0; i < 16; i++) begin wr_adr[i] = 3'd0; wr_dat[i] = 8'h0; wr_cyc[i] = 0; end
    for (int i = 0; i < 64; i++) begin adr_log[i] = 32'h0; req_log[i] = 1'b0; busy_log[i] = 1'b0; end
  endtask

  // Advance one cycle, drive memory/XCR responses for it, then record outputs.
  task automatic tick;
    @(posedge clk); #1;
    cyc++;
    xcr_busy  = (cyc >= busy_a && cyc <= busy_b);
    mem_rdy   = !(cyc >= rdy_lo_a && cyc <= rdy_lo_b);
    mem_rdata = mem_model(mem_adr);
    #1;
    if (cyc < 64) begin adr_log[cyc] = mem_adr; req_log[cyc] = mem_req; busy_log[cyc] = busy; end
    if (xcr_cs !== xcr_we) we_bad++;
    if (xcr_cs && wr_n < 16) begin
      wr_adr[wr_n] = xcr_adr; wr_dat[wr_n] = xcr_wdat; wr_cyc[wr_n] = cyc; wr_n++;
    end
    if (dack)   begin dack_n++;   dack_cyc = cyc;   dmiss_req = 1'b0; end
    if (dfault) begin dfault_n++; dfault_cyc = cyc; dmiss_req = 1'b0; end
    if (iack)   begin iack_n++;   iack_cyc = cyc;   imiss_req = 1'b0; end
    if (ifault) begin ifault_n++; ifault_cyc = cyc; imiss_req = 1'b0; end
  endtask

  task automatic idle_start;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_req, mem_adr, xcr_cs, xcr_we, xcr_adr, xcr_wdat, iack, dack, ifault, dfault, busy} !== 52'h0) begin
      fails++; $display("FAIL reset_outputs: got mem_req=%b mem_adr=%h xcr_cs=%b busy=%b, required all 0", mem_req, mem_adr, xcr_cs, busy);
    end
    rst = 1'b0;
    mmu_enable = 1'b1;
  endtask

  task automatic test_data_refill;
    pt_base = 16'h0012; dmiss_vpn = 8'h34;
    idle_start();
    dmiss_req = 1'b1;
    repeat (9) tick();
    tests++; if (!(req_log[1] === 1'b1 && adr_log[1] === 32'h0012_0268)) begin fails++; $display("FAIL data_rd_hi_adr: got req=%b adr=%h required 1 00120268", req_log[1], adr_log[1]); end
    tests++; if (!(req_log[2] === 1'b1 && adr_log[2] === 32'h0012_0269)) begin fails++; $display("FAIL data_rd_lo_adr: got req=%b adr=%h required 1 00120269", req_log[2], adr_log[2]); end
    tests++; if (wr_n !== 3) begin fails++; $display("FAIL data_wr_count: got %0d required 3", wr_n); end
    tests++; if ({wr_adr[0], wr_dat[0]} !== {3'd6, 8'hAB} || wr_cyc[0] !== 3) begin fails++; $display("FAIL data_wr_pah: got adr=%0d dat=%h cyc=%0d required 6 AB 3", wr_adr[0], wr_dat[0], wr_cyc[0]); end
    tests++; if ({wr_adr[1], wr_dat[1]} !== {3'd7, 8'hCD} || wr_cyc[1] !== 4) begin fails++; $display("FAIL data_wr_pal: got adr=%0d dat=%h cyc=%0d required 7 CD 4", wr_adr[1], wr_dat[1], wr_cyc[1]); end
    tests++; if ({wr_adr[2], wr_dat[2]} !== {3'd5, 8'h34} || wr_cyc[2] !== 5) begin fails++; $display("FAIL data_wr_tag: got adr=%0d dat=%h cyc=%0d required 5 34 5", wr_adr[2], wr_dat[2], wr_cyc[2]); end
    tests++; if (dack_cyc !== 6 || dack_n !== 1 || iack_n !== 0) begin fails++; $display("FAIL data_dack: got cyc=%0d n=%0d iack_n=%0d required 6 1 0", dack_cyc, dack_n, iack_n); end
    tests++; if (busy_log[7] !== 1'b0 || we_bad !== 0) begin fails++; $display("FAIL data_idle_after: got busy=%b we_bad=%0d required 0 0", busy_log[7], we_bad); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] e_adr [6];
    logic [7:0] e_dat [6];
    int         e_cyc [6];
    e_adr = '{3'd6, 3'd7, 3'd5, 3'd3, 3'd4, 3'd2};
    e_dat = '{8'h14, 8'h15, 8'h02, 8'h12, 8'h13, 8'h01};
    e_cyc = '{3, 4, 5, 10, 11, 12};
    pt_base = 16'h0012; dmiss_vpn = 8'h02; imiss_vpn = 8'h01;
    idle_start();
    dmiss_req = 1'b1; imiss_req = 1'b1;
    repeat (17) tick();
    tests++; if (dack_cyc !== 6 || busy_log[7] !== 1'b0) begin fails++; $display("FAIL b2b_dack: got cyc=%0d busy7=%b required 6 0", dack_cyc, busy_log[7]); end
    tests++; if (!(req_log[8] === 1'b1 && adr_log[8] === 32'h0012_0002)) begin fails++; $display("FAIL b2b_i_rd_hi: got req=%b adr=%h required 1 00120002", req_log[8], adr_log[8]); end
    tests++; if (!(req_log[9] === 1'b1 && adr_log[9] === 32'h0012_0003)) begin fails++; $display("FAIL b2b_i_rd_lo: got req=%b adr=%h required 1 00120003", req_log[9], adr_log[9]); end
    tests++; if (wr_n !== 6) begin fails++; $display("FAIL b2b_wr_count: got %0d required 6", wr_n); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (wr_adr[i] !== e_adr[i] || wr_dat[i] !== e_dat[i] || wr_cyc[i] !== e_cyc[i]) begin
        fails++; $display("FAIL b2b_wr%0d: got adr=%0d dat=%h cyc=%0d required %0d %h %0d", i, wr_adr[i], wr_dat[i], wr_cyc[i], e_adr[i], e_dat[i], e_cyc[i]);
      end
    end
    tests++; if (iack_cyc !== 13 || iack_n !== 1 || dack_n !== 1) begin fails++; $display("FAIL b2b_iack: got cyc=%0d iack_n=%0d dack_n=%0d required 13 1 1", iack_cyc, iack_n, dack_n); end
  endtask

  task automatic test_fault;
    pt_base = 16'h0040; dmiss_vpn = 8'h77;
    idle_start();
    dmiss_req = 1'b1;
    repeat (8) tick();
    tests++; if (adr_log[1] !== 32'h0040_02EE) begin fails++; $display("FAIL fault_rd_adr: got %h required 004002EE", adr_log[1]); end
    tests++; if (dfault_cyc !== 3 || dfault_n !== 1) begin fails++; $display("FAIL fault_pulse: got cyc=%0d n=%0d required 3 1", dfault_cyc, dfault_n); end
    tests++; if (wr_n !== 0 || dack_n !== 0 || ifault_n !== 0) begin fails++; $display("FAIL fault_no_write: got writes=%0d dack_n=%0d ifault_n=%0d required 0 0 0", wr_n, dack_n, ifault_n); end
    tests++; if (busy_log[4] !== 1'b0) begin fails++; $display("FAIL fault_idle_after: got busy=%b required 0", busy_log[4]); end
  endtask

  task automatic test_stall;
    pt_base = 16'h0012; dmiss_vpn = 8'h34;
    idle_start();
    rdy_lo_a = 1; rdy_lo_b = 2; busy_a = 6; busy_b = 9;
    dmiss_req = 1'b1;
    repeat (15) tick();
    tests++; if (adr_log[3] !== 32'h0012_0268 || adr_log[4] !== 32'h0012_0269) begin fails++; $display("FAIL stall_rd_adr: got %h %h required 00120268 00120269", adr_log[3], adr_log[4]); end
    tests++; if (wr_n !== 3) begin fails++; $display("FAIL stall_wr_count: got %0d required 3", wr_n); end
    tests++; if (wr_adr[0] !== 3'd6 || wr_cyc[0] !== 5 || wr_adr[1] !== 3'd7 || wr_dat[1] !== 8'hCD || wr_cyc[1] !== 10 || wr_adr[2] !== 3'd5 || wr_cyc[2] !== 11) begin
      fails++; $display("FAIL stall_wr_order: got %0d@%0d %0d:%h@%0d %0d@%0d required 6@5 7:CD@10 5@11", wr_adr[0], wr_cyc[0], wr_adr[1], wr_dat[1], wr_cyc[1], wr_adr[2], wr_cyc[2]);
    end
    tests++; if (dack_cyc !== 12) begin fails++; $display("FAIL stall_dack: got cyc=%0d required 12", dack_cyc); end
  endtask

  task automatic test_enable_gate;
    int hits;
    mmu_enable = 1'b0; pt_base = 16'h0012; imiss_vpn = 8'h01;
    idle_start();
    imiss_req = 1'b1;
    repeat (5) tick();
    hits = 0;
    for (int i = 1; i <= 5; i++) if (req_log[i] !== 1'b0 || busy_log[i] !== 1'b0) hits++;
    tests++; if (hits !== 0) begin fails++; $display("FAIL gate_disabled: got %0d active cycles required 0", hits); end
    clear_log();
    mmu_enable = 1'b1;
    repeat (8) tick();
    tests++; if (!(req_log[1] === 1'b1 && adr_log[1] === 32'h0012_0002)) begin fails++; $display("FAIL gate_start: got req=%b adr=%h required 1 00120002", req_log[1], adr_log[1]); end
    tests++; if (wr_n !== 3 || {wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1], wr_adr[2], wr_dat[2]} !== {3'd3, 8'h12, 3'd4, 8'h13, 3'd2, 8'h01}) begin
      fails++; $display("FAIL gate_writes: got n=%0d %0d:%h %0d:%h %0d:%h required 3 3:12 4:13 2:01", wr_n, wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1], wr_adr[2], wr_dat[2]);
    end
    tests++; if (iack_cyc !== 6) begin fails++; $display("FAIL gate_iack: got cyc=%0d required 6", iack_cyc); end
  endtask

  task automatic test_reset_midwalk;
    int tag_hits;
    pt_base = 16'h0012; dmiss_vpn = 8'h34;
    idle_start();
    dmiss_req = 1'b1;
    repeat (4) tick();
    rst = 1'b1; dmiss_req = 1'b0; mmu_enable = 1'b0;
    tick();
    tests++;
    if ({mem_req, mem_adr, xcr_cs, xcr_we, xcr_adr, xcr_wdat, iack, dack, ifault, dfault, busy} !== 52'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got mem_req=%b xcr_cs=%b xcr_adr=%0d busy=%b required all 0", mem_req, xcr_cs, xcr_adr, busy);
    end
    rst = 1'b0;
    repeat (8) tick();
    tag_hits = 0;
    for (int i = 0; i < wr_n; i++) if (wr_adr[i] === 3'd5) tag_hits++;
    tests++; if (tag_hits !== 0 || wr_n !== 2) begin fails++; $display("FAIL rst_mid_no_tag: got tag_writes=%0d writes=%0d required 0 2", tag_hits, wr_n); end
    tests++; if (dack_n !== 0 || dfault_n !== 0) begin fails++; $display("FAIL rst_mid_no_ack: got dack_n=%0d dfault_n=%0d required 0 0", dack_n, dfault_n); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_data_refill();
    test_back_to_back();
    test_fault();
    test_stall();
    test_enable_gate();
    test_reset_midwalk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
